seven_seg_scan_controller: RTL

//   Time-multiplexes NUM_DIGITS hex digits onto one shared 7-segment encoder and one shared segment bus.

---
 rtl/seven_seg_scan_controller.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_controller.sv
// Multiplexed hex display scanner: one shared 7-segment encoder and one
// shared segment bus, scanned digit by digit with dark gaps between digits
// to suppress ghosting. The display value is taken through a valid/ready
// handshake and only changes at frame boundaries (or while scanning is off).
module seven_seg_scan_controller #(
  parameter int NUM_DIGITS       = 4,
  parameter int SCAN_DIV         = 50000,
  parameter int BLANK_CYCLES     = 16,
  parameter int ACTIVE_LOW_ANODE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic                    blank_lz,
  output logic [3:0]              hex_nibble,
  input  logic [7:0]              hex_segments,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  // One counter serves both phases, so it is sized for the longer one.
  localparam int CNT_LIM = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_LIM > 1) ? $clog2(CNT_LIM) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]      SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF    = {NUM_DIGITS{ACTIVE_LOW_ANODE != 0}};

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [NUM_DIGITS-1:0][3:0]     disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]          disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0][3:0]     pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]          pend_dp_q, pend_dp_d;
  // load_ready low means the pending register holds a value not yet shown.
  logic                           load_ready_q, load_ready_d;
  logic [7:0]                     seg_out_q, seg_out_d;
  logic [NUM_DIGITS-1:0]          digit_sel_q, digit_sel_d;
  logic                           frame_done_q, frame_done_d;

  logic                           apply;
  logic                           lit;
  logic                           zero_above;
  logic [NUM_DIGITS-1:0]          lz_blank;
  logic [NUM_DIGITS-1:0]          onehot;

  assign hex_nibble = disp_val_q[idx_q];
  assign load_ready = load_ready_q;
  assign seg_out    = seg_out_q;
  assign digit_sel  = digit_sel_q;
  assign frame_done = frame_done_q;

  // Leading-zero mask: digit i>0 is dark when it and every higher nibble are zero.
  always_comb begin
    lz_blank   = '0;
    zero_above = blank_lz;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above  = zero_above && (disp_val_q[i] == 4'h0);
      lz_blank[i] = zero_above;
    end
  end

  // Scan FSM, frame boundary detection and load handshake.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    apply        = 1'b0;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    load_ready_d = load_ready_q;

    if (!enable) begin
      // Scanning off: park at the start of digit 0 and flush any pending value.
      state_d = ST_BLANK;
      cnt_d   = '0;
      idx_d   = '0;
      apply   = !load_ready_q;
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
              frame_done_d = 1'b1;
              apply        = !load_ready_q;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_BLANK;
      endcase
    end

    // Transfer and apply never coincide: one needs ready high, the other low.
    if (apply) begin
      disp_val_d   = pend_val_q;
      disp_dp_d    = pend_dp_q;
      load_ready_d = 1'b1;
    end else if (load_valid && load_ready_q) begin
      pend_val_d   = load_value;
      pend_dp_d    = load_dp;
      load_ready_d = 1'b0;
    end
  end

  // Pin drivers: registered one cycle behind state/idx; dark whenever not showing.
  always_comb begin
    lit         = enable && (state_q == ST_SHOW);
    onehot      = '0;
    onehot[idx_q] = 1'b1;
    seg_out_d   = 8'hFF;
    digit_sel_d = SEL_OFF;
    if (lit) begin
      seg_out_d   = {~disp_dp_q[idx_q], lz_blank[idx_q] ? 7'h7F : hex_segments[6:0]};
      digit_sel_d = (ACTIVE_LOW_ANODE != 0) ? ~onehot : onehot;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      load_ready_q <= 1'b1;
      seg_out_q    <= 8'hFF;
      digit_sel_q  <= SEL_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      load_ready_q <= load_ready_d;
      seg_out_q    <= seg_out_d;
      digit_sel_q  <= digit_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
